// File: rtl/arb_2to1_stream.sv
`default_nettype none
// ============================================================================
//  Module   : arb_2to1_stream
//  Purpose  : Two-source round-robin stream arbiter. Selects between sources
//             A and B with valid/ready handshakes and loads the winning word
//             into a one-entry output register. It also exports the select
//             line and per-source grant counters.
//  Ports    : clk, reset (async, active-high)
//             a_valid/a_data/a_ready  - source A handshake
//             b_valid/b_data/b_ready  - source B handshake
//             o_valid/o_data/o_ready  - output register handshake
//             s                       - source of current/last word (0=A,1=B)
//             cnt_a/cnt_b             - wrap-around grant counters
//  Revision : 1.0 - initial release
// ============================================================================
module arb_2to1_stream #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             o_ready,
    output logic             s,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    logic             o_valid_q;
    logic [WIDTH-1:0] o_data_q;
    logic             s_q;
    logic             last_q;
    logic [CNT_W-1:0] cnt_a_q;
    logic [CNT_W-1:0] cnt_b_q;

    logic             load_en_d;
    logic             grant_a_d;
    logic             grant_b_d;

    // Ready is held low while reset is asserted so that no source can see a
    // handshake complete for a word the register is about to discard.
    assign load_en_d = ~reset & (~o_valid_q | o_ready);

    // last_q == 1 means B won most recently, so A wins a tie (and vice versa).
    assign grant_a_d = load_en_d & a_valid & (~b_valid |  last_q);
    assign grant_b_d = load_en_d & b_valid & (~a_valid | ~last_q);

    assign a_ready = grant_a_d;
    assign b_ready = grant_b_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            s_q       <= 1'b0;
            last_q    <= 1'b1;
            cnt_a_q   <= '0;
            cnt_b_q   <= '0;
        end else if (load_en_d) begin
            if (grant_a_d) begin
                o_valid_q <= 1'b1;
                o_data_q  <= a_data;
                s_q       <= 1'b0;
                last_q    <= 1'b0;
                cnt_a_q   <= cnt_a_q + 1'b1;
            end else if (grant_b_d) begin
                o_valid_q <= 1'b1;
                o_data_q  <= b_data;
                s_q       <= 1'b1;
                last_q    <= 1'b1;
                cnt_b_q   <= cnt_b_q + 1'b1;
            end else begin
                // Drained with nothing to replace it: go empty, keep the rest.
                o_valid_q <= 1'b0;
            end
        end
    end

    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign s       = s_q;
    assign cnt_a   = cnt_a_q;
    assign cnt_b   = cnt_b_q;

endmodule
`default_nettype wire

// File: tb/tb_arb_2to1_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arb_2to1_stream
//  Purpose  : Self-checking bench for arb_2to1_stream using a table of
//             directed vectors plus hand-written reset and wrap sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_arb_2to1_stream;

    localparam int WIDTH = 8;
    localparam int CNT_W = 8;
    localparam int NVEC  = 17;

    logic             clk;
    logic             reset;
    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_ready;
    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_ready;
    logic             o_valid;
    logic [WIDTH-1:0] o_data;
    logic             o_ready;
    logic             s;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;

    int n_checks;
    int n_fail;

    typedef struct {
        logic             av;
        logic [WIDTH-1:0] ad;
        logic             bv;
        logic [WIDTH-1:0] bd;
        logic             ordy;
        logic             e_ar;
        logic             e_br;
        logic             e_ov;
        logic [WIDTH-1:0] e_od;
        logic             e_s;
        logic [CNT_W-1:0] e_ca;
        logic [CNT_W-1:0] e_cb;
    } vec_t;

    vec_t vecs [NVEC];

    arb_2to1_stream #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .a_valid (a_valid),
        .a_data  (a_data),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_data  (b_data),
        .b_ready (b_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_ready (o_ready),
        .s       (s),
        .cnt_a   (cnt_a),
        .cnt_b   (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic av, input logic [WIDTH-1:0] ad,
                         input logic bv, input logic [WIDTH-1:0] bd,
                         input logic ordy);
        a_valid = av;
        a_data  = ad;
        b_valid = bv;
        b_data  = bd;
        o_ready = ordy;
    endtask

    task automatic chk_regs(input string tag, input logic ov, input logic [WIDTH-1:0] od,
                            input logic es, input logic [CNT_W-1:0] ca,
                            input logic [CNT_W-1:0] cb);
        chk({tag, ".o_valid"}, 32'(o_valid), 32'(ov));
        chk({tag, ".o_data"},  32'(o_data),  32'(od));
        chk({tag, ".s"},       32'(s),       32'(es));
        chk({tag, ".cnt_a"},   32'(cnt_a),   32'(ca));
        chk({tag, ".cnt_b"},   32'(cnt_b),   32'(cb));
    endtask

    task automatic put(input int i, input logic av, input logic [7:0] ad,
                       input logic bv, input logic [7:0] bd, input logic ordy,
                       input logic ar, input logic br, input logic ov,
                       input logic [7:0] od, input logic es,
                       input logic [7:0] ca, input logic [7:0] cb);
        vecs[i] = '{av, ad, bv, bd, ordy, ar, br, ov, od, es, ca, cb};
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

        //        av ad     bv bd     ordy  ar br  ov od    s  ca    cb
        // Tie from reset: alternate A,B,A,B
        put( 0, 1, 8'h11, 1, 8'h22, 1,    1, 0,  1, 8'h11, 0, 8'd1, 8'd0);
        put( 1, 1, 8'h11, 1, 8'h22, 1,    0, 1,  1, 8'h22, 1, 8'd1, 8'd1);
        put( 2, 1, 8'h11, 1, 8'h22, 1,    1, 0,  1, 8'h11, 0, 8'd2, 8'd1);
        put( 3, 1, 8'h11, 1, 8'h22, 1,    0, 1,  1, 8'h22, 1, 8'd2, 8'd2);
        // Backpressure: load 0x5A, then hold 5 cycles with both sources valid
        put( 4, 1, 8'h5A, 0, 8'h00, 1,    1, 0,  1, 8'h5A, 0, 8'd3, 8'd2);
        put( 5, 1, 8'h77, 1, 8'h88, 0,    0, 0,  1, 8'h5A, 0, 8'd3, 8'd2);
        put( 6, 1, 8'h77, 1, 8'h88, 0,    0, 0,  1, 8'h5A, 0, 8'd3, 8'd2);
        put( 7, 1, 8'h77, 1, 8'h88, 0,    0, 0,  1, 8'h5A, 0, 8'd3, 8'd2);
        put( 8, 1, 8'h77, 1, 8'h88, 0,    0, 0,  1, 8'h5A, 0, 8'd3, 8'd2);
        put( 9, 1, 8'h77, 1, 8'h88, 0,    0, 0,  1, 8'h5A, 0, 8'd3, 8'd2);
        // Release: drain and load in the same edge; last was A so B wins
        put(10, 1, 8'h77, 1, 8'h88, 1,    0, 1,  1, 8'h88, 1, 8'd3, 8'd3);
        // Single source B streaming
        put(11, 0, 8'h00, 1, 8'h01, 1,    0, 1,  1, 8'h01, 1, 8'd3, 8'd4);
        put(12, 0, 8'h00, 1, 8'h02, 1,    0, 1,  1, 8'h02, 1, 8'd3, 8'd5);
        put(13, 0, 8'h00, 1, 8'h03, 1,    0, 1,  1, 8'h03, 1, 8'd3, 8'd6);
        // Drain with no grant -> empty, data/s/counters hold
        put(14, 0, 8'h00, 0, 8'h00, 1,    0, 0,  0, 8'h03, 1, 8'd3, 8'd6);
        // Empty stays empty even with o_ready low
        put(15, 0, 8'h00, 0, 8'h00, 0,    0, 0,  0, 8'h03, 1, 8'd3, 8'd6);
        // Empty register loads regardless of o_ready
        put(16, 1, 8'h33, 0, 8'h00, 0,    1, 0,  1, 8'h33, 0, 8'd4, 8'd6);

        // Reset held for 2 cycles, idle inputs
        repeat (2) begin
            @(posedge clk);
            #1;
            chk_regs("rst", 1'b0, 8'h00, 1'b0, 8'd0, 8'd0);
            chk("rst.a_ready", 32'(a_ready), 32'd0);
            chk("rst.b_ready", 32'(b_ready), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("idle.a_ready", 32'(a_ready), 32'd0);
        chk("idle.b_ready", 32'(b_ready), 32'd0);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i].av, vecs[i].ad, vecs[i].bv, vecs[i].bd, vecs[i].ordy);
            #1;
            chk($sformatf("v%0d.a_ready", i), 32'(a_ready), 32'(vecs[i].e_ar));
            chk($sformatf("v%0d.b_ready", i), 32'(b_ready), 32'(vecs[i].e_br));
            @(posedge clk);
            #1;
            chk_regs($sformatf("v%0d", i), vecs[i].e_ov, vecs[i].e_od, vecs[i].e_s,
                     vecs[i].e_ca, vecs[i].e_cb);
        end

        // Reset mid-stream: register holds 0x33 with o_ready low
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        chk_regs("hold33", 1'b1, 8'h33, 1'b0, 8'd4, 8'd6);
        #2;
        reset = 1'b1;
        #1;
        chk_regs("async_rst", 1'b0, 8'h00, 1'b0, 8'd0, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
        #1;
        chk("post_rst.a_ready", 32'(a_ready), 32'd1);
        chk("post_rst.b_ready", 32'(b_ready), 32'd0);
        @(posedge clk);
        #1;
        chk_regs("post_rst", 1'b1, 8'h11, 1'b0, 8'd1, 8'd0);

        // Counter wrap: 257 grants of A from a fresh reset
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        a_valid = 1'b1;
        for (int k = 1; k <= 257; k++) begin
            a_data = 8'(k);
            @(posedge clk);
            #1;
            if (k == 255) chk("wrap255.cnt_a", 32'(cnt_a), 32'd255);
            if (k == 256) chk("wrap256.cnt_a", 32'(cnt_a), 32'd0);
            @(negedge clk);
        end
        chk_regs("wrap257", 1'b1, 8'h01, 1'b0, 8'd1, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
